// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared states, pattern codes and beep counts for beep_sequencer
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Encoding doubles as priority: a larger code wins.
  typedef enum logic [1:0] {
    PAT_NONE   = 2'd0,
    PAT_OK     = 2'd1,
    PAT_CANCEL = 2'd2,
    PAT_ERR    = 2'd3
  } pat_e;

  localparam logic [1:0] OK_BEEPS     = 2'd1;
  localparam logic [1:0] ERR_BEEPS    = 2'd3;
  localparam logic [1:0] CANCEL_BEEPS = 2'd2;

  function automatic pat_e pick_event(input logic ok, input logic err, input logic cancel);
    pat_e p;
    p = PAT_NONE;
    if (ok)     p = PAT_OK;
    if (cancel) p = PAT_CANCEL;
    if (err)    p = PAT_ERR;
    return p;
  endfunction

  function automatic logic [1:0] beeps_of(input pat_e p);
    logic [1:0] n;
    case (p)
      PAT_OK:     n = OK_BEEPS;
      PAT_CANCEL: n = CANCEL_BEEPS;
      PAT_ERR:    n = ERR_BEEPS;
      default:    n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// rtl/beep_sequencer_if.sv - event inputs and buzzer outputs of beep_sequencer
interface beep_sequencer_if;
  logic evt_ok;
  logic evt_err;
  logic evt_cancel;
  logic key;
  logic busy;

  modport master (output evt_ok, evt_err, evt_cancel, input key, busy);
  modport slave  (input evt_ok, evt_err, evt_cancel, output key, busy);
endinterface

// File: rtl/beep_sequencer_ms_tick.sv
// rtl/beep_sequencer_ms_tick.sv - ms prescaler with sync clear, 1-cycle tick every TICK_DIV cycles
module ms_tick #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - ticket-machine beep pattern sequencer; BEEP_QUEUE_EN adds a one-deep pending event
module beep_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int SHORT_MS = 100,
  parameter int LONG_MS  = 500,
  parameter int GAP_MS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  beep_sequencer_if.slave bus
);
  import beep_pkg::*;

  localparam int MS_MAX = (LONG_MS > SHORT_MS) ?
                          ((LONG_MS > GAP_MS) ? LONG_MS : GAP_MS) :
                          ((SHORT_MS > GAP_MS) ? SHORT_MS : GAP_MS);
  localparam int MS_W = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  state_e          state_q, state_d;
  pat_e            pat_q, pat_d;
  logic [1:0]      left_q, left_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            key_q, key_d;
  logic            abort_q, abort_d;
  logic            tick;
  logic            tick_clr;
  pat_e            evt;
  pat_e            start;
  logic [MS_W-1:0] on_last;
`ifdef BEEP_QUEUE_EN
  pat_e            pend_q, pend_d;
`endif

  ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign evt     = pick_event(bus.evt_ok, bus.evt_err, bus.evt_cancel);
  assign on_last = (pat_q == PAT_OK) ? MS_W'(LONG_MS - 1) : MS_W'(SHORT_MS - 1);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    left_d   = left_q;
    key_d    = key_q;
    abort_d  = abort_q;
    ms_d     = tick ? ms_q + 1'b1 : ms_q;
    tick_clr = 1'b0;
    start    = evt;
`ifdef BEEP_QUEUE_EN
    pend_d   = pend_q;
    if (pend_q > start) start = pend_q;
`endif
    case (state_q)
      IDLE: begin
        tick_clr = 1'b1;
        ms_d     = '0;
        if (start != PAT_NONE) begin
          state_d = ON;
          key_d   = 1'b1;
          pat_d   = start;
          left_d  = beeps_of(start) - 2'd1;
`ifdef BEEP_QUEUE_EN
          pend_d  = PAT_NONE;
`endif
        end
      end
      default: begin
        if (evt == PAT_ERR && pat_q != PAT_ERR) begin
          // Abort via a one-cycle GAP; left=3 so the GAP exit starts err beep one.
          state_d  = GAP;
          key_d    = 1'b0;
          pat_d    = PAT_ERR;
          left_d   = ERR_BEEPS;
          abort_d  = 1'b1;
          tick_clr = 1'b1;
          ms_d     = '0;
        end else begin
`ifdef BEEP_QUEUE_EN
          if (evt > pend_q) pend_d = evt;
`endif
          if (state_q == ON) begin
            if (tick && ms_q == on_last) begin
              state_d  = GAP;
              key_d    = 1'b0;
              tick_clr = 1'b1;
              ms_d     = '0;
            end
          end else if (abort_q || (tick && ms_q == MS_W'(GAP_MS - 1))) begin
            tick_clr = 1'b1;
            ms_d     = '0;
            abort_d  = 1'b0;
            if (left_q != 2'd0) begin
              state_d = ON;
              key_d   = 1'b1;
              left_d  = left_q - 2'd1;
            end else begin
              state_d = IDLE;
              pat_d   = PAT_NONE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_NONE;
      left_q  <= '0;
      ms_q    <= '0;
      key_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      left_q  <= left_d;
      ms_q    <= ms_d;
      key_q   <= key_d;
      abort_q <= abort_d;
    end
  end

`ifdef BEEP_QUEUE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= PAT_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign bus.key  = key_q;
  assign bus.busy = (state_q != IDLE);
endmodule
